// File: rtl/nios2_system_v0_ctrl_pio_if.sv
// rtl/nios2_system_v0_ctrl_pio_if.sv - Avalon-MM slave register bus for the control PIO
interface nios2_system_v0_ctrl_pio_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/nios2_system_v0_ctrl_pio.sv
// rtl/nios2_system_v0_ctrl_pio.sv - control PIO: set/clear/pulse outputs, edge-captured inputs, irq
module nios2_system_v0_ctrl_pio #(
    parameter int          WIDTH        = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int          PULSE_CYCLES = 16,
    parameter int          EDGE_TYPE    = 0
) (
    input  logic                           clk,
    input  logic                           reset_n,
    nios2_system_v0_ctrl_pio_if.slave      bus,
    output logic [WIDTH-1:0]               out_port,
    input  logic [WIDTH-1:0]               in_port,
    output logic                           irq
);
    localparam int CW = $clog2(PULSE_CYCLES + 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [WIDTH-1:0] data_out, data_nx;
    logic [WIDTH-1:0] pulse_mask, mask_nx;
    logic [WIDTH-1:0] irqmask, irqmask_nx;
    logic [WIDTH-1:0] edgecap, edgecap_nx;
    logic [WIDTH-1:0] sync1, sync2, sync_prev;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] wd;
    logic             wr;
    logic             unused_wd;

    assign wr        = bus.chipselect & ~bus.write_n;
    assign wd        = bus.writedata[WIDTH-1:0];
    assign unused_wd = ^bus.writedata;

    generate
        if (EDGE_TYPE == 0) begin : g_rise
            assign edge_hit = sync2 & ~sync_prev;
        end else if (EDGE_TYPE == 1) begin : g_fall
            assign edge_hit = ~sync2 & sync_prev;
        end else begin : g_any
            assign edge_hit = sync2 ^ sync_prev;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            data_out   <= RESET_VALUE;
            pulse_mask <= '0;
            irqmask    <= '0;
            edgecap    <= '0;
            sync1      <= '0;
            sync2      <= '0;
            sync_prev  <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            data_out   <= data_nx;
            pulse_mask <= mask_nx;
            irqmask    <= irqmask_nx;
            edgecap    <= edgecap_nx;
            sync1      <= in_port;
            sync2      <= sync1;
            sync_prev  <= sync2;
        end
    end

    // Pulse expiry is resolved first so a bus write on the same cycle overrides it.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        data_nx    = data_out;
        mask_nx    = pulse_mask;
        irqmask_nx = irqmask;
        edgecap_nx = edgecap;

        if (state == ACTIVE) begin
            if (cnt == CW'(1)) begin
                data_nx  = data_out & ~pulse_mask;
                mask_nx  = '0;
                state_nx = IDLE;
                cnt_nx   = '0;
            end else if (pulse_mask == '0) begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end else begin
                cnt_nx = cnt - CW'(1);
            end
        end

        if (wr) begin
            case (bus.address)
                3'd0: begin
                    data_nx  = wd;
                    mask_nx  = '0;
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
                3'd2: irqmask_nx = wd;
                3'd3: edgecap_nx = edgecap & ~wd;
                3'd4: data_nx = data_nx | wd;
                3'd5: begin
                    data_nx = data_nx & ~wd;
                    mask_nx = mask_nx & ~wd;
                end
                3'd6: begin
                    if (wd != '0) begin
                        data_nx  = data_nx | wd;
                        mask_nx  = mask_nx | wd;
                        state_nx = ACTIVE;
                        cnt_nx   = CW'(PULSE_CYCLES);
                    end
                end
                default: ;
            endcase
        end

        // A fresh edge beats a simultaneous write-1-to-clear.
        edgecap_nx = edgecap_nx | edge_hit;
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            3'd0: bus.readdata = 32'(data_out);
            3'd1: bus.readdata = 32'(sync2);
            3'd2: bus.readdata = 32'(irqmask);
            3'd3: bus.readdata = 32'(edgecap);
            3'd6: bus.readdata = 32'(pulse_mask);
            default: bus.readdata = '0;
        endcase
    end

    assign out_port = data_out;
    assign irq      = |(edgecap & irqmask);
endmodule

// File: tb/tb_nios2_system_v0_ctrl_pio.sv
// tb/tb_nios2_system_v0_ctrl_pio.sv - scoreboard bench for the control PIO against a cycle-count model
module tb_nios2_system_v0_ctrl_pio;
    localparam int         N    = 16;
    localparam logic [7:0] RSTV = 8'hA5;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] out_port;
    logic [7:0] in_port = '0;
    logic       irq;

    nios2_system_v0_ctrl_pio_if bus();

    nios2_system_v0_ctrl_pio #(
        .WIDTH(8), .RESET_VALUE(RSTV), .PULSE_CYCLES(N), .EDGE_TYPE(0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .out_port(out_port), .in_port(in_port), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] rd;
        logic [7:0]  op;
        logic        irq;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: pulsed bits drop at an absolute cycle deadline; inputs seen through a history queue.
    logic [7:0] m_data, m_mask, m_irqmask, m_edgecap, m_sync;
    int         m_cyc, m_deadline;
    logic [7:0] hist[$];
    logic [7:0] cur_in;

    function automatic logic [31:0] exp_rd(input logic [2:0] a);
        case (a)
            3'd0: return {24'd0, m_data};
            3'd1: return {24'd0, m_sync};
            3'd2: return {24'd0, m_irqmask};
            3'd3: return {24'd0, m_edgecap};
            3'd6: return {24'd0, m_mask};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_data = RSTV; m_mask = '0; m_irqmask = '0; m_edgecap = '0; m_sync = '0;
        m_cyc = 0; m_deadline = 0;
        hist.delete();
        repeat (3) hist.push_back(8'h00);
    endtask

    task automatic model_edge(input bit w, input logic [2:0] a, input logic [7:0] wd, input logic [7:0] inp);
        logic [7:0] rises;
        m_cyc++;
        hist.push_back(inp);
        rises = hist[hist.size()-3] & ~hist[hist.size()-4];
        if (w && a == 3'd3) m_edgecap = m_edgecap & ~wd;
        m_edgecap = m_edgecap | rises;
        m_sync = hist[hist.size()-2];
        if (m_mask != 0 && m_cyc == m_deadline) begin
            m_data = m_data & ~m_mask;
            m_mask = '0;
        end
        if (w) begin
            case (a)
                3'd0: begin m_data = wd; m_mask = '0; end
                3'd2: m_irqmask = wd;
                3'd4: m_data = m_data | wd;
                3'd5: begin m_data = m_data & ~wd; m_mask = m_mask & ~wd; end
                3'd6: if (wd != 0) begin
                    m_data = m_data | wd; m_mask = m_mask | wd; m_deadline = m_cyc + N;
                end
                default: ;
            endcase
        end
        while (hist.size() > 8) void'(hist.pop_front());
    endtask

    // Called just after a rising edge: drive, record expectations for this cycle, advance to next edge.
    task automatic cyc(input bit cs, input bit wn, input logic [2:0] a, input logic [7:0] wd);
        exp_t e;
        bus.chipselect = cs;
        bus.write_n    = wn;
        bus.address    = a;
        bus.writedata  = {24'($urandom), wd};
        in_port        = cur_in;
        e.addr = a; e.rd = exp_rd(a); e.op = m_data; e.irq = |(m_edgecap & m_irqmask);
        sb.push_back(e);
        @(posedge clk);
        model_edge(cs & ~wn, a, wd, cur_in);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] wd);
        cyc(1'b1, 1'b0, a, wd);
    endtask

    task automatic rd(input logic [2:0] a, input int n);
        for (int k = 0; k < n; k++) cyc(1'b1, 1'b1, a, 8'($urandom));
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            vectors++;
            if (bus.readdata !== e.rd) begin
                miscompares++;
                $display("FAIL readdata[%0d] t=%0t: got %08h want %08h", e.addr, $time, bus.readdata, e.rd);
            end
            vectors++;
            if (out_port !== e.op) begin
                miscompares++;
                $display("FAIL out_port t=%0t: got %02h want %02h", $time, out_port, e.op);
            end
            vectors++;
            if (irq !== e.irq) begin
                miscompares++;
                $display("FAIL irq t=%0t: got %0b want %0b", $time, irq, e.irq);
            end
        end
    end

    task automatic random_phase(input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] wd;
            if ($urandom_range(0, 9) == 0) cur_in = cur_in ^ 8'($urandom);
            if ($urandom_range(0, 3) == 0) wd = 8'(1 << $urandom_range(0, 7));
            else if ($urandom_range(0, 7) == 0) wd = 8'h00;
            else wd = 8'($urandom);
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                3'($urandom_range(0, 7)), wd);
        end
    endtask

    initial begin
        exp_t e;
        cur_in = '0;
        bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.address = '0; bus.writedata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Reset state: every register readable, out_port at its reset value.
        for (int a = 0; a < 8; a++) cyc(1'b0, 1'b1, 3'(a), 8'h00);

        wr(3'd0, 8'h0F); wr(3'd4, 8'h30); wr(3'd5, 8'h03); rd(3'd0, 2);

        wr(3'd0, 8'h00); wr(3'd6, 8'h01); rd(3'd6, N + 4);

        wr(3'd6, 8'h01); rd(3'd6, 9); wr(3'd6, 8'h02); rd(3'd0, 5);
        wr(3'd5, 8'h01); rd(3'd6, N + 2);
        wr(3'd6, 8'h00); rd(3'd6, 2);

        wr(3'd2, 8'h04);
        cur_in = 8'h04; rd(3'd3, 5);
        wr(3'd3, 8'h04); rd(3'd3, 2);
        cur_in = 8'h00; rd(3'd1, 4);
        cur_in = 8'h04; rd(3'd1, 2);
        wr(3'd3, 8'h04); rd(3'd3, 3);
        wr(3'd3, 8'hFF);

        random_phase(1500);

        // Asynchronous reset in the middle of a pulse.
        wr(3'd6, 8'h0F); rd(3'd6, 5);
        reset_n = 1'b0;
        bus.chipselect = 1'b0; bus.address = 3'd6; cur_in = '0; in_port = '0;
        e.addr = 3'd6; e.rd = 32'd0; e.op = RSTV; e.irq = 1'b0;
        sb.push_back(e);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        rd(3'd6, N + 4);

        random_phase(500);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
